// File: rtl/bpsk_burst_mod.sv
// Gated BPSK burst modulator: a 16-sample carrier whose sign is set by a PRBS7 bit.
// Each gate rise starts one burst, and the burst always ends on a whole symbol.
//
// state | meaning
// IDLE  | waiting for a gate rising edge; outputs held at zero
// RUN   | gate still high; carrier and symbols advancing
// DRAIN | gate has dropped; finishing the current symbol, then IDLE
module bpsk_burst_mod #(
  parameter int SYM_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gate,
  output logic signed [11:0] sample,
  output logic               sample_valid,
  output logic               sym_bit,
  output logic               sym_strobe,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [3:0] CYC_LAST = 4'(SYM_CYC - 1);

  state_t     state;
  logic       g_d;
  logic [3:0] phase;
  logic [3:0] cyc_cnt;
  logic [6:0] lfsr;
  logic       rise;
  logic       sym_end;

  assign rise    = gate & ~g_d;
  assign sym_end = (phase == 4'hF) && (cyc_cnt == CYC_LAST);

  // Only the first quarter-wave pair is tabulated; the second half is its negation.
  function automatic logic signed [11:0] sin16(input logic [3:0] p);
    logic signed [11:0] m;
    case (p[2:0])
      3'd0:    m = 12'sd0;
      3'd1:    m = 12'sd783;
      3'd2:    m = 12'sd1447;
      3'd3:    m = 12'sd1891;
      3'd4:    m = 12'sd2047;
      3'd5:    m = 12'sd1891;
      3'd6:    m = 12'sd1447;
      default: m = 12'sd783;
    endcase
    return p[3] ? -m : m;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      g_d          <= 1'b0;
      phase        <= 4'd0;
      cyc_cnt      <= 4'd0;
      lfsr         <= 7'h7F;
      sample       <= 12'sd0;
      sample_valid <= 1'b0;
      sym_bit      <= 1'b0;
      sym_strobe   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      g_d <= gate;

      if (state == IDLE) begin
        sample       <= 12'sd0;
        sample_valid <= 1'b0;
        sym_bit      <= 1'b0;
        sym_strobe   <= 1'b0;
        busy         <= 1'b0;
      end else begin
        sample       <= lfsr[6] ? sin16(phase) : -sin16(phase);
        sample_valid <= 1'b1;
        sym_bit      <= lfsr[6];
        sym_strobe   <= (phase == 4'd0) && (cyc_cnt == 4'd0);
        busy         <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state   <= RUN;
            phase   <= 4'd0;
            cyc_cnt <= 4'd0;
            lfsr    <= 7'h7F;
          end
        end
        RUN, DRAIN: begin
          phase <= phase + 4'd1;
          if (phase == 4'hF)
            cyc_cnt <= (cyc_cnt == CYC_LAST) ? 4'd0 : cyc_cnt + 4'd1;
          // The symbol changes only at a carrier zero crossing.
          if (sym_end)
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
          if (state == RUN && !gate)
            state <= DRAIN;
          else if (state == DRAIN && sym_end)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_burst_mod.sv
// Scoreboard bench for bpsk_burst_mod: stimulus queues the expected samples, and the
// monitor pops one entry for every valid sample the design presents.
module tb_bpsk_burst_mod;

  localparam int SYM_CYC = 4;
  localparam int SYM_LEN = 16 * SYM_CYC;

  logic               clk;
  logic               rst;
  logic               gate;
  logic signed [11:0] sample;
  logic               sample_valid;
  logic               sym_bit;
  logic               sym_strobe;
  logic               busy;

  bpsk_burst_mod #(.SYM_CYC(SYM_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .gate         (gate),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sym_bit      (sym_bit),
    .sym_strobe   (sym_strobe),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s;
    bit b;
    bit st;
  } exp_t;

  exp_t q[$];
  int   cap_s[$];
  bit   cap_b[$];
  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;
  int   scount = 0;
  bit   prev_valid = 0;
  bit   prev_bit = 0;

  int sin_tab[16] = '{0, 783, 1447, 1891, 2047, 1891, 1447, 783,
                      0, -783, -1447, -1891, -2047, -1891, -1447, -783};

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Every burst restarts the PRBS at 7'h7F.
  task automatic push_symbols(input int n);
    logic [6:0] m;
    exp_t e;
    m = 7'h7F;
    for (int s = 0; s < n; s++) begin
      for (int c = 0; c < SYM_LEN; c++) begin
        e.b  = m[6];
        e.s  = m[6] ? sin_tab[c % 16] : -sin_tab[c % 16];
        e.st = (c == 0);
        q.push_back(e);
      end
      m = {m[5:0], m[6] ^ m[5]};
    end
  endtask

  task automatic clear_capture();
    cap_s.delete();
    cap_b.delete();
    vcount = 0;
    scount = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles, want 0", busy, budget);
    end
  endtask

  task automatic pulse_gate_one();
    @(negedge clk) gate = 1'b1;
    @(posedge clk);
    @(negedge clk) gate = 1'b0;
  endtask

  always @(negedge clk) begin
    int sv;
    exp_t e;
    if (rst && sample_valid) begin
      sv = sample;
      vcount++;
      if (sym_strobe) scount++;
      cap_s.push_back(sv);
      cap_b.push_back(sym_bit);
      if (prev_valid && !sym_strobe) begin
        checks++;
        if (sym_bit != prev_bit) begin
          errors++;
          $display("FAIL bit_change: sym_bit %0d changed without strobe, was %0d", sym_bit, prev_bit);
        end
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got %0d want no sample", sv);
      end else begin
        e = q.pop_front();
        if (sv != e.s || sym_bit != e.b || sym_strobe != e.st) begin
          errors++;
          $display("FAIL sample: got %0d bit %0d strobe %0d want %0d bit %0d strobe %0d",
                   sv, sym_bit, sym_strobe, e.s, e.b, e.st);
        end
      end
    end
    prev_valid = rst && sample_valid;
    prev_bit   = sym_bit;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int bits;
    bit idle_bad;

    rst  = 1'b0;
    gate = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sample", sample, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_strobe", sym_strobe, 0);
    chk("reset_bit", sym_bit, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_valid", sample_valid, 0);

    // Gate held 1000 clocks: 15.625 symbols, drained out to 16.
    clear_capture();
    push_symbols(16);
    @(negedge clk) gate = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("latency_not_yet", sample_valid, 0);
    @(negedge clk);
    chk("latency_first_valid", sample_valid, 1);
    chk("latency_first_strobe", sym_strobe, 1);
    repeat (998) @(posedge clk);
    @(negedge clk) gate = 1'b0;
    wait_idle(200);
    chk("long_count", vcount, 16 * SYM_LEN);
    chk("long_strobes", scount, 16);
    chk("long_queue_left", q.size(), 0);
    if (cap_s.size() >= 16 * SYM_LEN) begin
      chk("long_s0", cap_s[0], 0);
      chk("long_s1", cap_s[1], 783);
      chk("long_s2", cap_s[2], 1447);
      chk("long_sym7_s0", cap_s[7 * SYM_LEN], 0);
      chk("long_sym7_s1", cap_s[7 * SYM_LEN + 1], -783);
      bits = 0;
      for (int k = 0; k < 8; k++) bits = (bits << 1) | int'(cap_b[k * SYM_LEN]);
      chk("long_bit_seq", bits, 8'b1111_1110);
    end else begin
      chk("long_capture_size", cap_s.size(), 16 * SYM_LEN);
    end
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || sample_valid || sample != 0) idle_bad = 1;
    end
    chk("long_stays_idle", idle_bad, 0);

    // One-clock gate still yields one full symbol.
    clear_capture();
    push_symbols(1);
    pulse_gate_one();
    wait_idle(200);
    chk("short_count", vcount, SYM_LEN);
    chk("short_strobes", scount, 1);
    chk("short_sample_after", sample, 0);
    chk("short_busy_after", busy, 0);

    // Second rise during DRAIN is ignored; gate left high afterwards gives no restart.
    clear_capture();
    push_symbols(1);
    pulse_gate_one();
    repeat (10) @(negedge clk);
    gate = 1'b1;
    wait_idle(200);
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || sample_valid) idle_bad = 1;
    end
    chk("drain_rerise_no_restart", idle_bad, 0);
    chk("drain_rerise_count", vcount, SYM_LEN);
    gate = 1'b0;
    repeat (3) @(negedge clk);
    clear_capture();
    push_symbols(1);
    pulse_gate_one();
    wait_idle(200);
    chk("clean_rise_count", vcount, SYM_LEN);

    // Reset mid-symbol, then release with gate high: restart from phase 0, lfsr 7'h7F.
    clear_capture();
    push_symbols(16);
    @(negedge clk) gate = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_sample", sample, 0);
    chk("midreset_valid", sample_valid, 0);
    chk("midreset_busy", busy, 0);
    q.delete();
    clear_capture();
    push_symbols(1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) gate = 1'b0;
    wait_idle(200);
    chk("restart_count", vcount, SYM_LEN);
    if (cap_s.size() >= 2) begin
      chk("restart_s1", cap_s[1], 783);
      chk("restart_bit", cap_b[0], 1);
    end else begin
      chk("restart_capture_size", cap_s.size(), SYM_LEN);
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
